// File: rtl/decode_bypass_stage.sv
// Decode/operand-read stage: forwarding bypass, one-entry skid, registered output.
// DECODE_BYPASS_SNOOP_EN: refresh held output operands from forwarding ports.
module decode_bypass_stage #(
    parameter int XLEN      = 32,
    parameter int RADDR_W   = 5,
    parameter int PAYLOAD_W = 64,
    parameter int NUM_FWD   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       u_valid,
    output logic                       u_stall,
    input  logic [RADDR_W-1:0]         in_rs1,
    input  logic [RADDR_W-1:0]         in_rs2,
    input  logic [RADDR_W-1:0]         in_rd,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    output logic [RADDR_W-1:0]         read0_addr,
    output logic [RADDR_W-1:0]         read1_addr,
    input  logic [XLEN-1:0]            read0_val,
    input  logic [XLEN-1:0]            read1_val,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_val,
    input  logic                       flush,
    output logic                       d_valid,
    input  logic                       d_stall,
    output logic [RADDR_W-1:0]         out_rs1,
    output logic [RADDR_W-1:0]         out_rs2,
    output logic [RADDR_W-1:0]         out_rd,
    output logic [XLEN-1:0]            out_rs1val,
    output logic [XLEN-1:0]            out_rs2val,
    output logic [PAYLOAD_W-1:0]       out_payload
);

    logic                 skidValid;
    logic [RADDR_W-1:0]   skidRs1;
    logic [RADDR_W-1:0]   skidRs2;
    logic [RADDR_W-1:0]   skidRd;
    logic [PAYLOAD_W-1:0] skidPayload;

    logic                 curValid;
    logic [RADDR_W-1:0]   curRs1;
    logic [RADDR_W-1:0]   curRs2;
    logic [RADDR_W-1:0]   curRd;
    logic [PAYLOAD_W-1:0] curPayload;
    logic [XLEN-1:0]      curRs1Val;
    logic [XLEN-1:0]      curRs2Val;
    logic [XLEN-1:0]      heldRs1Val;
    logic [XLEN-1:0]      heldRs2Val;

    // Lowest index wins because it is assigned last; x0 always reads as zero.
    function automatic logic [XLEN-1:0] resolve(
        input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0]    base
    );
        logic [XLEN-1:0] r;
        r = base;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_rd[i*RADDR_W +: RADDR_W] == addr)
                r = fwd_val[i*XLEN +: XLEN];
        end
        if (addr == '0)
            r = '0;
        return r;
    endfunction

    assign u_stall = skidValid;

    always_comb begin
        curValid   = u_valid;
        curRs1     = in_rs1;
        curRs2     = in_rs2;
        curRd      = in_rd;
        curPayload = in_payload;
        if (skidValid) begin
            curValid   = 1'b1;
            curRs1     = skidRs1;
            curRs2     = skidRs2;
            curRd      = skidRd;
            curPayload = skidPayload;
        end
    end

    assign read0_addr = curRs1;
    assign read1_addr = curRs2;
    assign curRs1Val  = resolve(curRs1, read0_val);
    assign curRs2Val  = resolve(curRs2, read1_val);

`ifdef DECODE_BYPASS_SNOOP_EN
    assign heldRs1Val = d_valid ? resolve(out_rs1, out_rs1val) : out_rs1val;
    assign heldRs2Val = d_valid ? resolve(out_rs2, out_rs2val) : out_rs2val;
`else
    assign heldRs1Val = out_rs1val;
    assign heldRs2Val = out_rs2val;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid     <= 1'b0;
            skidValid   <= 1'b0;
            skidRs1     <= '0;
            skidRs2     <= '0;
            skidRd      <= '0;
            skidPayload <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_rs1val  <= '0;
            out_rs2val  <= '0;
            out_payload <= '0;
        end else if (flush) begin
            d_valid   <= 1'b0;
            skidValid <= 1'b0;
        end else if (!d_stall) begin
            d_valid     <= curValid;
            skidValid   <= 1'b0;
            out_rs1     <= curRs1;
            out_rs2     <= curRs2;
            out_rd      <= curRd;
            out_rs1val  <= curRs1Val;
            out_rs2val  <= curRs2Val;
            out_payload <= curPayload;
        end else begin
            // Skid keeps addresses only; operands are re-read when it drains.
            skidValid   <= curValid;
            skidRs1     <= curRs1;
            skidRs2     <= curRs2;
            skidRd      <= curRd;
            skidPayload <= curPayload;
            out_rs1val  <= heldRs1Val;
            out_rs2val  <= heldRs2Val;
        end
    end

endmodule

// File: tb/tb_decode_bypass_stage.sv
// Directed testbench for decode_bypass_stage with a small regfile model.
module tb_decode_bypass_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        u_valid;
    logic        u_stall;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [63:0] in_payload;
    logic [4:0]  read0_addr, read1_addr;
    logic [31:0] read0_val, read1_val;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_val;
    logic        flush;
    logic        d_valid;
    logic        d_stall;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_rs1val, out_rs2val;
    logic [63:0] out_payload;

    logic [31:0] rf [32];
    int nChecks = 0;
    int nFails  = 0;

`ifdef DECODE_BYPASS_SNOOP_EN
    localparam logic [31:0] SNOOP_EXP = 32'h55;
`else
    localparam logic [31:0] SNOOP_EXP = 32'h33;
`endif

    decode_bypass_stage dut (
        .clk(clk), .rst(rst),
        .u_valid(u_valid), .u_stall(u_stall),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_payload(in_payload),
        .read0_addr(read0_addr), .read1_addr(read1_addr),
        .read0_val(read0_val), .read1_val(read1_val),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_val(fwd_val),
        .flush(flush),
        .d_valid(d_valid), .d_stall(d_stall),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1val(out_rs1val), .out_rs2val(out_rs2val),
        .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    always_comb begin
        read0_val = rf[read0_addr];
        read1_val = rf[read1_addr];
    end

    task automatic initRf();
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hDEAD;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic driveUop(input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [63:0] p);
        in_rs1 = a;
        in_rs2 = b;
        in_rd = c;
        in_payload = p;
        u_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) stepClk();
        nChecks += 6;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL rst_dvalid: got %b expected 0", d_valid); end
        if (u_stall !== 1'b0) begin nFails++; $display("FAIL rst_ustall: got %b expected 0", u_stall); end
        if (out_rs1val !== 32'h0) begin nFails++; $display("FAIL rst_rs1val: got %h expected 0", out_rs1val); end
        if (out_rs2val !== 32'h0) begin nFails++; $display("FAIL rst_rs2val: got %h expected 0", out_rs2val); end
        if (out_payload !== 64'h0) begin nFails++; $display("FAIL rst_payload: got %h expected 0", out_payload); end
        if (out_rd !== 5'h0) begin nFails++; $display("FAIL rst_rd: got %h expected 0", out_rd); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        rf[5] = 32'h11;
        driveUop(5'd5, 5'd0, 5'd9, 64'hF0);
        d_stall = 1'b0;
        fwd_valid = 2'b11;
        fwd_rd = {5'd5, 5'd5};
        fwd_val = {32'hBB, 32'hAA};
        stepClk();
        nChecks += 4;
        if (out_rs1val !== 32'hAA) begin nFails++; $display("FAIL fwd_prio_rs1: got %h expected aa", out_rs1val); end
        if (out_rs2val !== 32'h0) begin nFails++; $display("FAIL fwd_prio_rs2: got %h expected 0", out_rs2val); end
        if (d_valid !== 1'b1) begin nFails++; $display("FAIL fwd_prio_dvalid: got %b expected 1", d_valid); end
        if (out_rd !== 5'd9) begin nFails++; $display("FAIL fwd_prio_rd: got %h expected 9", out_rd); end
        @(negedge clk);
        fwd_valid = 2'b10;
        stepClk();
        nChecks++;
        if (out_rs1val !== 32'hBB) begin nFails++; $display("FAIL fwd_port1: got %h expected bb", out_rs1val); end
        @(negedge clk);
        fwd_valid = 2'b01;
        fwd_rd = {5'd5, 5'd0};
        fwd_val = {32'hBB, 32'hCC};
        stepClk();
        nChecks += 2;
        if (out_rs1val !== 32'h11) begin nFails++; $display("FAIL fwd_miss_rf: got %h expected 11", out_rs1val); end
        if (out_rs2val !== 32'h0) begin nFails++; $display("FAIL fwd_x0_ignored: got %h expected 0", out_rs2val); end
        @(negedge clk);
        fwd_valid = 2'b00;
        u_valid = 1'b0;
        stepClk();
        nChecks++;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL fwd_idle: got %b expected 0", d_valid); end
    endtask

    task automatic test_skid_release();
        @(negedge clk);
        driveUop(5'd1, 5'd2, 5'd10, 64'hA);
        d_stall = 1'b0;
        stepClk();
        nChecks++;
        if (out_payload !== 64'hA) begin nFails++; $display("FAIL skid_loadA: got %h expected a", out_payload); end
        @(negedge clk);
        driveUop(5'd6, 5'd7, 5'd11, 64'hB);
        d_stall = 1'b1;
        nChecks++;
        if (u_stall !== 1'b0) begin nFails++; $display("FAIL skid_accept: got %b expected 0", u_stall); end
        stepClk();
        nChecks += 2;
        if (u_stall !== 1'b1) begin nFails++; $display("FAIL skid_ustall: got %b expected 1", u_stall); end
        if (out_payload !== 64'hA) begin nFails++; $display("FAIL skid_holdA: got %h expected a", out_payload); end
        @(negedge clk);
        u_valid = 1'b0;
        fwd_valid = 2'b10;
        fwd_rd = {5'd7, 5'd0};
        fwd_val = {32'h1234, 32'h0};
        rf[6] = 32'h666;
        stepClk();
        nChecks += 2;
        if (u_stall !== 1'b1) begin nFails++; $display("FAIL skid_ustall2: got %b expected 1", u_stall); end
        if (d_valid !== 1'b1) begin nFails++; $display("FAIL skid_dvalid: got %b expected 1", d_valid); end
        @(negedge clk);
        fwd_valid = 2'b00;
        rf[7] = 32'h1234;
        stepClk();
        @(negedge clk);
        d_stall = 1'b0;
        stepClk();
        nChecks += 6;
        if (d_valid !== 1'b1) begin nFails++; $display("FAIL drain_dvalid: got %b expected 1", d_valid); end
        if (out_payload !== 64'hB) begin nFails++; $display("FAIL drain_payload: got %h expected b", out_payload); end
        if (out_rd !== 5'd11) begin nFails++; $display("FAIL drain_rd: got %h expected b", out_rd); end
        if (out_rs1val !== 32'h666) begin nFails++; $display("FAIL drain_fresh_rs1: got %h expected 666", out_rs1val); end
        if (out_rs2val !== 32'h1234) begin nFails++; $display("FAIL drain_stale_fix: got %h expected 1234", out_rs2val); end
        if (u_stall !== 1'b0) begin nFails++; $display("FAIL drain_ustall: got %b expected 0", u_stall); end
        @(negedge clk);
        stepClk();
        nChecks++;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL drain_nodup: got %b expected 0", d_valid); end
    endtask

    task automatic test_snoop();
        @(negedge clk);
        rf[3] = 32'h33;
        rf[4] = 32'h44;
        driveUop(5'd3, 5'd4, 5'd12, 64'hC);
        d_stall = 1'b0;
        stepClk();
        nChecks++;
        if (out_rs1val !== 32'h33) begin nFails++; $display("FAIL snoop_load: got %h expected 33", out_rs1val); end
        @(negedge clk);
        u_valid = 1'b0;
        d_stall = 1'b1;
        fwd_valid = 2'b01;
        fwd_rd = {5'd0, 5'd3};
        fwd_val = {32'h0, 32'h55};
        stepClk();
        nChecks += 4;
        if (out_rs1val !== SNOOP_EXP) begin nFails++; $display("FAIL snoop_rs1: got %h expected %h", out_rs1val, SNOOP_EXP); end
        if (out_rs2val !== 32'h44) begin nFails++; $display("FAIL snoop_rs2: got %h expected 44", out_rs2val); end
        if (u_stall !== 1'b0) begin nFails++; $display("FAIL snoop_nobubble: got %b expected 0", u_stall); end
        if (d_valid !== 1'b1) begin nFails++; $display("FAIL snoop_dvalid: got %b expected 1", d_valid); end
        @(negedge clk);
        fwd_valid = 2'b00;
        d_stall = 1'b0;
        stepClk();
        nChecks++;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL snoop_release: got %b expected 0", d_valid); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        driveUop(5'd1, 5'd2, 5'd13, 64'hD);
        d_stall = 1'b0;
        stepClk();
        @(negedge clk);
        driveUop(5'd2, 5'd3, 5'd14, 64'hE);
        d_stall = 1'b1;
        stepClk();
        nChecks += 2;
        if (u_stall !== 1'b1) begin nFails++; $display("FAIL flush_pre_ustall: got %b expected 1", u_stall); end
        if (d_valid !== 1'b1) begin nFails++; $display("FAIL flush_pre_dvalid: got %b expected 1", d_valid); end
        @(negedge clk);
        u_valid = 1'b0;
        flush = 1'b1;
        stepClk();
        nChecks += 2;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL flush_dvalid: got %b expected 0", d_valid); end
        if (u_stall !== 1'b0) begin nFails++; $display("FAIL flush_ustall: got %b expected 0", u_stall); end
        @(negedge clk);
        flush = 1'b0;
        d_stall = 1'b0;
        stepClk();
        nChecks++;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL flush_skid_gone: got %b expected 0", d_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        driveUop(5'd8, 5'd9, 5'd15, 64'hF);
        d_stall = 1'b0;
        stepClk();
        @(negedge clk);
        driveUop(5'd9, 5'd10, 5'd16, 64'h10);
        d_stall = 1'b1;
        stepClk();
        @(negedge clk);
        u_valid = 1'b0;
        rst = 1'b1;
        flush = 1'b1;
        stepClk();
        nChecks += 7;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL rstmid_dvalid: got %b expected 0", d_valid); end
        if (u_stall !== 1'b0) begin nFails++; $display("FAIL rstmid_ustall: got %b expected 0", u_stall); end
        if (out_rs1val !== 32'h0) begin nFails++; $display("FAIL rstmid_rs1val: got %h expected 0", out_rs1val); end
        if (out_rs2val !== 32'h0) begin nFails++; $display("FAIL rstmid_rs2val: got %h expected 0", out_rs2val); end
        if (out_payload !== 64'h0) begin nFails++; $display("FAIL rstmid_payload: got %h expected 0", out_payload); end
        if (out_rd !== 5'h0) begin nFails++; $display("FAIL rstmid_rd: got %h expected 0", out_rd); end
        if (out_rs1 !== 5'h0) begin nFails++; $display("FAIL rstmid_rs1: got %h expected 0", out_rs1); end
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        d_stall = 1'b0;
        stepClk();
        nChecks++;
        if (d_valid !== 1'b0) begin nFails++; $display("FAIL rstmid_skid_gone: got %b expected 0", d_valid); end
    endtask

    task automatic test_back_to_back();
        int nextId = 0;
        int expOut = 0;
        int cycles = 0;
        logic accept, bubble;
        logic [4:0] eRs2;
        logic [31:0] eRs2Val;
        initRf();
        while (expOut < 100 && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            d_stall = ($urandom_range(0, 2) == 0);
            if (!u_stall) begin
                if (nextId < 100 && $urandom_range(0, 3) != 0)
                    driveUop(5'((nextId % 31) + 1), 5'(nextId % 32),
                             5'(nextId), 64'hB2B0_0000_0000 | 64'(nextId));
                else
                    u_valid = 1'b0;
            end
            accept = u_valid && !u_stall;
            bubble = !u_valid && !u_stall;
            if (d_valid && !d_stall) begin
                eRs2 = 5'(expOut % 32);
                eRs2Val = (eRs2 == 5'd0) ? 32'h0 : rf[eRs2];
                nChecks += 3;
                if (out_payload !== (64'hB2B0_0000_0000 | 64'(expOut))) begin
                    nFails++;
                    $display("FAIL b2b_payload: got %h expected id %0d", out_payload, expOut);
                end
                if (out_rs1val !== rf[(expOut % 31) + 1]) begin
                    nFails++;
                    $display("FAIL b2b_rs1val: got %h expected %h", out_rs1val, rf[(expOut % 31) + 1]);
                end
                if (out_rs2val !== eRs2Val) begin
                    nFails++;
                    $display("FAIL b2b_rs2val: got %h expected %h", out_rs2val, eRs2Val);
                end
                expOut++;
            end
            stepClk();
            if (accept) nextId++;
            if (bubble) begin
                nChecks++;
                if (u_stall !== 1'b0) begin nFails++; $display("FAIL b2b_bubble_buffered: got %b expected 0", u_stall); end
            end
        end
        nChecks++;
        if (expOut != 100) begin nFails++; $display("FAIL b2b_timeout: got %0d expected 100", expOut); end
        @(negedge clk);
        u_valid = 1'b0;
        d_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepClk();
            nChecks++;
            if (d_valid !== 1'b0) begin nFails++; $display("FAIL b2b_extra: got %b expected 0", d_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        u_valid = 1'b0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_rd = '0;
        in_payload = '0;
        fwd_valid = '0;
        fwd_rd = '0;
        fwd_val = '0;
        flush = 1'b0;
        d_stall = 1'b0;
        initRf();
        test_reset();
        test_fwd_priority();
        test_skid_release();
        test_snoop();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
